// File: rtl/shreg_pkg.sv
// Shared types for the universal shift/ring register: mode encoding, direction codes
// and a one-hot helper.
package shreg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD    = 3'd0,
      MODE_LOAD    = 3'd1,
      MODE_SHIFT   = 3'd2,
      MODE_ROTATE  = 3'd3,
      MODE_JOHNSON = 3'd4
   } mode_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Callers zero-extend narrower registers to 32 bits.
   function automatic logic is_onehot(input logic [31:0] v);
      return ($countones(v) == 1);
   endfunction

endpackage

// File: rtl/shreg_step_cnt.sv
// Step counter for the universal shift register.
// Counts steps modulo the active period and produces a one-cycle registered wrap pulse.
module shreg_step_cnt #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CW    = $clog2(2 * WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          step,
   input  logic          clr,
   input  logic          dbl,
   output logic [CW-1:0] step_cnt,
   output logic          wrap
);

   // One extra bit so that a period of 2*WIDTH is representable.
   localparam int unsigned PW = CW + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap_q, wrap_d;
   logic [PW-1:0] period;
   logic [PW-1:0] nxt;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      period = dbl ? PW'(2 * WIDTH) : PW'(WIDTH);
      nxt    = {1'b0, cnt_q} + PW'(1);
      if (clr) begin
         cnt_d = '0;
      end else if (step) begin
         if (nxt >= period) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = nxt[CW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign step_cnt = cnt_q;
   assign wrap     = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift/ring register: hold, load, serial shift, rotate and Johnson modes.
// Define ONEHOT_CHK_EN to build the sticky one-hot check that drives err during ROTATE.
module univ_shift_reg
   import shreg_pkg::*;
#(
   parameter  int unsigned      WIDTH   = 4,
   parameter  logic [WIDTH-1:0] RST_VAL = {1'b1, {(WIDTH-1){1'b0}}},
   localparam int unsigned      CW      = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ser_in,
   output logic [WIDTH-1:0] out,
   output logic             ser_out,
   output logic [CW-1:0]    step_cnt,
   output logic             wrap,
   output logic             err
);

   mode_e            mode_s;
   logic [WIDTH-1:0] out_q, out_d;
   logic             cnt_step, cnt_clr, cnt_dbl;

   assign mode_s = mode_e'(mode);

   // Datapath next state; reserved encodings fall through to hold.
   always_comb begin
      out_d    = out_q;
      cnt_step = 1'b0;
      cnt_clr  = 1'b0;
      cnt_dbl  = 1'b0;
      if (en) begin
         case (mode_s)
            MODE_LOAD: begin
               out_d   = load_val;
               cnt_clr = 1'b1;
            end
            MODE_SHIFT: begin
               out_d    = (dir == DIR_LEFT) ? {out_q[WIDTH-2:0], ser_in}
                                            : {ser_in, out_q[WIDTH-1:1]};
               cnt_step = 1'b1;
            end
            MODE_ROTATE: begin
               out_d    = (dir == DIR_LEFT) ? {out_q[WIDTH-2:0], out_q[WIDTH-1]}
                                            : {out_q[0], out_q[WIDTH-1:1]};
               cnt_step = 1'b1;
            end
            MODE_JOHNSON: begin
               out_d    = (dir == DIR_LEFT) ? {out_q[WIDTH-2:0], ~out_q[WIDTH-1]}
                                            : {~out_q[0], out_q[WIDTH-1:1]};
               cnt_step = 1'b1;
               cnt_dbl  = 1'b1;
            end
            default: out_d = out_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= RST_VAL;
      else        out_q <= out_d;
   end

   shreg_step_cnt #(.WIDTH(WIDTH)) u_step_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (cnt_step),
      .clr      (cnt_clr),
      .dbl      (cnt_dbl),
      .step_cnt (step_cnt),
      .wrap     (wrap)
   );

`ifdef ONEHOT_CHK_EN
   logic err_q, err_d;

   // Sticky flag on a rotate step from a non-one-hot value; only LOAD or reset clears it.
   always_comb begin
      err_d = err_q;
      if (en) begin
         if (mode_s == MODE_LOAD)
            err_d = 1'b0;
         else if (mode_s == MODE_ROTATE && !is_onehot(32'(out_q)))
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign out     = out_q;
   assign ser_out = (dir == DIR_LEFT) ? out_q[WIDTH-1] : out_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: vector table plus reset corner sequences.
module tb_univ_shift_reg;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 3;
`ifdef ONEHOT_CHK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, ROT = 3'd3, JOHN = 3'd4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [2:0]    mode;
   logic          dir;
   logic [W-1:0]  load_val;
   logic          ser_in;
   logic [W-1:0]  out;
   logic          ser_out;
   logic [CW-1:0] step_cnt;
   logic          wrap;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic          en;
      logic [2:0]    mode;
      logic          dir;
      logic [W-1:0]  load_val;
      logic          ser_in;
      logic [W-1:0]  exp_out;
      logic [CW-1:0] exp_cnt;
      logic          exp_wrap;
      logic          exp_ser;
      logic          exp_err;
   } vec_t;

   vec_t vecs[$];

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load_val (load_val),
      .ser_in   (ser_in),
      .out      (out),
      .ser_out  (ser_out),
      .step_cnt (step_cnt),
      .wrap     (wrap),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic e, input logic [2:0] m, input logic d,
                      input logic [W-1:0] lv, input logic si, input logic [W-1:0] eo,
                      input logic [CW-1:0] ec, input logic ew, input logic es,
                      input logic ee);
      vec_t v;
      v.en = e; v.mode = m; v.dir = d; v.load_val = lv; v.ser_in = si;
      v.exp_out = eo; v.exp_cnt = ec; v.exp_wrap = ew; v.exp_ser = es; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   task automatic check_all(input int idx, input logic [W-1:0] eo, input logic [CW-1:0] ec,
                            input logic ew, input logic es, input logic ee);
      check("out", idx, 32'(out), 32'(eo));
      check("step_cnt", idx, 32'(step_cnt), 32'(ec));
      check("wrap", idx, 32'(wrap), 32'(ew));
      check("ser_out", idx, 32'(ser_out), 32'(es));
      check("err", idx, 32'(err), 32'(ee));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = HOLD; dir = 1'b0; load_val = '0; ser_in = 1'b0;

      // Ring rotate right from reset value.
      add(1, ROT, 0, 4'h0, 0, 4'b0100, 3'd1, 0, 0, 0);
      add(1, ROT, 0, 4'h0, 0, 4'b0010, 3'd2, 0, 0, 0);
      add(1, ROT, 0, 4'h0, 0, 4'b0001, 3'd3, 0, 1, 0);
      add(1, ROT, 0, 4'h0, 0, 4'b1000, 3'd0, 1, 0, 0);
      // Load then rotate left with an enable gap.
      add(1, LOAD, 1, 4'b0001, 0, 4'b0001, 3'd0, 0, 0, 0);
      add(1, ROT, 1, 4'h0, 0, 4'b0010, 3'd1, 0, 0, 0);
      add(1, ROT, 1, 4'h0, 0, 4'b0100, 3'd2, 0, 0, 0);
      add(0, ROT, 1, 4'h0, 0, 4'b0100, 3'd2, 0, 0, 0);
      add(0, ROT, 1, 4'h0, 0, 4'b0100, 3'd2, 0, 0, 0);
      add(0, ROT, 1, 4'h0, 0, 4'b0100, 3'd2, 0, 0, 0);
      add(1, ROT, 1, 4'h0, 0, 4'b1000, 3'd3, 0, 1, 0);
      add(1, ROT, 1, 4'h0, 0, 4'b0001, 3'd0, 1, 0, 0);
      add(0, ROT, 1, 4'h0, 0, 4'b0001, 3'd0, 0, 0, 0);
      // Johnson right, full period of 8.
      add(1, LOAD, 0, 4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1000, 3'd1, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1100, 3'd2, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1110, 3'd3, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1111, 3'd4, 0, 1, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b0111, 3'd5, 0, 1, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b0011, 3'd6, 0, 1, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b0001, 3'd7, 0, 1, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b0000, 3'd0, 1, 0, 0);
      // Johnson to step 6, then switch to rotate: shorter period wraps at once.
      add(1, LOAD, 0, 4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1000, 3'd1, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1100, 3'd2, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1110, 3'd3, 0, 0, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b1111, 3'd4, 0, 1, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b0111, 3'd5, 0, 1, 0);
      add(1, JOHN, 0, 4'h0, 0, 4'b0011, 3'd6, 0, 1, 0);
      add(1, ROT,  0, 4'h0, 0, 4'b1001, 3'd0, 1, 1, CHK);
      // Serial shift right, reserved mode, hold, then shift left.
      add(1, LOAD,  0, 4'b0000, 0, 4'b0000, 3'd0, 0, 0, 0);
      add(1, SHIFT, 0, 4'h0, 1, 4'b1000, 3'd1, 0, 0, 0);
      add(1, SHIFT, 0, 4'h0, 0, 4'b0100, 3'd2, 0, 0, 0);
      add(1, SHIFT, 0, 4'h0, 1, 4'b1010, 3'd3, 0, 0, 0);
      add(1, SHIFT, 0, 4'h0, 1, 4'b1101, 3'd0, 1, 1, 0);
      add(1, 3'd6,  0, 4'h0, 0, 4'b1101, 3'd0, 0, 1, 0);
      add(1, HOLD,  0, 4'h0, 0, 4'b1101, 3'd0, 0, 1, 0);
      add(1, SHIFT, 1, 4'h0, 0, 4'b1010, 3'd1, 0, 1, 0);
      // Non-one-hot rotate: sticky err until the next load.
      add(1, LOAD, 0, 4'b0110, 0, 4'b0110, 3'd0, 0, 0, 0);
      add(1, ROT,  0, 4'h0, 0, 4'b0011, 3'd1, 0, 1, CHK);
      add(1, ROT,  0, 4'h0, 0, 4'b1001, 3'd2, 0, 1, CHK);
      add(1, ROT,  0, 4'h0, 0, 4'b1100, 3'd3, 0, 0, CHK);
      add(1, ROT,  0, 4'h0, 0, 4'b0110, 3'd0, 1, 0, CHK);
      add(1, LOAD, 0, 4'b0001, 0, 4'b0001, 3'd0, 0, 1, 0);

      // Reset held for two edges.
      repeat (2) @(posedge clk);
      #1;
      check_all(-1, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         en = vecs[i].en; mode = vecs[i].mode; dir = vecs[i].dir;
         load_val = vecs[i].load_val; ser_in = vecs[i].ser_in;
         @(posedge clk);
         #1;
         check_all(i, vecs[i].exp_out, vecs[i].exp_cnt, vecs[i].exp_wrap,
                   vecs[i].exp_ser, vecs[i].exp_err);
      end

      // Asynchronous reset mid-rotation, observed without a clock edge.
      en = 1'b1; mode = ROT; dir = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_out", -2, 32'(out), 32'(4'b0100));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out", -2, 32'(out), 32'(4'b1000));
      check("async_rst_cnt", -2, 32'(step_cnt), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_out", -3, 32'(out), 32'(4'b0100));
      check("post_rst_cnt", -3, 32'(step_cnt), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
